// File: rtl/debug_step_ctrl.sv
// ============================================================================
// Module   : debug_step_ctrl
// Brief    : Debug run-control: pause / single-step / divided free-run / burst
//            CPU clock-enable, executed-cycle counter and display-page select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_step_ctrl #(
  parameter int unsigned RUN_DIV = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned SEL_MAX = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_pulse,
  input  logic             run_pulse,
  input  logic             burst_pulse,
  input  logic             sel_pulse,
  input  logic [7:0]       burst_len,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_cnt,
  output logic [SEL_W-1:0] disp_sel
);

  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BURST = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] step_cnt_q;
  logic [SEL_W-1:0] disp_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PAUSE;
      cpu_en_q    <= 1'b0;
      div_cnt_q   <= '0;
      remaining_q <= '0;
      step_cnt_q  <= '0;
      disp_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_en_q    <= cpu_en_d;
      div_cnt_q   <= div_cnt_d;
      remaining_q <= remaining_d;
      step_cnt_q  <= step_cnt_q + CNT_W'(cpu_en_q);
      if (sel_pulse) begin
        disp_sel_q <= (disp_sel_q == SEL_W'(SEL_MAX)) ? '0 : disp_sel_q + SEL_W'(1);
      end
    end
  end

  // cpu_en_d is derived from the next state so the enable lands in the same
  // cycle the new mode becomes visible.
  always_comb begin
    state_d     = state_q;
    cpu_en_d    = 1'b0;
    div_cnt_d   = div_cnt_q;
    remaining_d = remaining_q;
    case (state_q)
      PAUSE: begin
        div_cnt_d   = '0;
        remaining_d = '0;
        // The highest-priority pulse present wins even when it is then refused.
        if (run_pulse) begin
          if (!halt) begin
            state_d  = RUN;
            cpu_en_d = (div_cnt_d == DIV_LAST);
          end
        end else if (burst_pulse) begin
          if (!halt && (burst_len != 8'd0)) begin
            state_d     = BURST;
            remaining_d = burst_len;
            cpu_en_d    = 1'b1;
          end
        end else if (step_pulse) begin
          state_d  = STEP;
          cpu_en_d = 1'b1;
        end
      end
      STEP: begin
        state_d = PAUSE;
      end
      RUN: begin
        if (run_pulse || halt) begin
          state_d   = PAUSE;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
          cpu_en_d  = (div_cnt_d == DIV_LAST);
        end
      end
      BURST: begin
        if (run_pulse || halt || (remaining_q == 8'd1)) begin
          state_d     = PAUSE;
          remaining_d = '0;
        end else begin
          remaining_d = remaining_q - 8'd1;
          cpu_en_d    = 1'b1;
        end
      end
      default: begin
        state_d = PAUSE;
      end
    endcase
  end

  assign cpu_en   = cpu_en_q;
  assign mode     = state_q;
  assign step_cnt = step_cnt_q;
  assign disp_sel = disp_sel_q;

endmodule

`default_nettype wire
